// File: rtl/fcvt_pkg.sv
// Shared types and helpers for the float-to-integer conversion path.
package fcvt_pkg;

  // RISC-V rounding-mode encodings; 5..7 fall back to round-to-nearest-even.
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef struct packed {
    logic nv;
    logic nx;
  } fcvt_flags_t;

  // Decide whether the truncated integer part must be bumped by one.
  function automatic logic round_inc(input logic [2:0] rm, input logic s,
                                     input logic lsb, input logic g, input logic st);
    case (rm)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return s & (g | st);
      RM_RUP:  return ~s & (g | st);
      RM_RMM:  return g;
      default: return g & (st | lsb);
    endcase
  endfunction

endpackage

// File: rtl/fcvt_ws_shift.sv
// Decode an IEEE-754 single and align it to an integer part plus guard/sticky.
module fcvt_ws_shift #(
  parameter int OUT_W = 32
) (
  input  logic [31:0]    x,
  output logic           s,
  output logic [OUT_W:0] i_part,
  output logic           g,
  output logic           st,
  output logic           is_nan,
  output logic           is_inf
);

  localparam int VW = OUT_W + 25;
  localparam logic signed [9:0] MAX_E = 10'(OUT_W);

  logic [7:0]         e;
  logic [22:0]        m;
  logic [23:0]        sig;
  logic signed [9:0]  exp_unb;
  logic [9:0]         sh;
  logic [VW-1:0]      v;

  assign s       = x[31];
  assign e       = x[30:23];
  assign m       = x[22:0];
  assign sig     = {|e, m};
  assign exp_unb = $signed({2'b00, e}) - 10'sd127;
  assign is_nan  = (&e) & (|m);
  assign is_inf  = (&e) & ~(|m);

  // Place sig at bit (E+1) of a fixed-point word whose low 24 bits are the
  // fraction; tiny values collapse into sticky, huge ones are capped at 2^OUT_W.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    i_part = '0;
    g      = 1'b0;
    st     = 1'b0;
    v      = '0;
    sh     = '0;
    if (&e) begin
      // NaN / infinity: the saturation stage ignores the magnitude.
    end else if (exp_unb < -10'sd1) begin
      st = |sig;
    end else if (exp_unb > MAX_E) begin
      i_part = {1'b1, {OUT_W{1'b0}}};
    end else begin
      sh     = exp_unb + 10'sd1;
      v      = {{(OUT_W+1){1'b0}}, sig} << sh;
      i_part = v[VW-1:24];
      g      = v[23];
      st     = |v[22:0];
    end
  end

endmodule

// File: rtl/fcvt_ws_pipe.sv
// Pipelined FCVT.W.S / FCVT.WU.S with valid/ready flow control, all RISC-V
// rounding modes, saturation and NV/NX flags.
module fcvt_ws_pipe
  import fcvt_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [2:0]       rm,
  input  logic             is_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             flag_nv,
  output logic             flag_nx
);

  typedef struct packed {
    logic           s;
    logic [OUT_W:0] i_part;
    logic           g;
    logic           st;
    logic           is_nan;
    logic           is_inf;
    logic [2:0]     rm;
    logic           uns;
  } shift_t;

  typedef struct packed {
    logic           s;
    logic [OUT_W:0] mag;
    logic           gs;
    logic           is_nan;
    logic           is_inf;
    logic           uns;
  } round_t;

  localparam logic [OUT_W:0]   HALF = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] ZERO = '0;

  logic           adv;
  logic           dec_s, dec_g, dec_st, dec_nan, dec_inf;
  logic [OUT_W:0] dec_i;
  shift_t         sh_c, sh_r;
  logic           sh_v;
  logic           inc;
  round_t         rd_c, rd_r;
  logic           rd_v;
  logic           in_range;
  logic [OUT_W-1:0] y_c;
  fcvt_flags_t    fl_c, fl_q;

  // The whole pipe moves together; it only freezes when the result is refused.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  fcvt_ws_shift #(.OUT_W(OUT_W)) u_shift (
    .x      (x),
    .s      (dec_s),
    .i_part (dec_i),
    .g      (dec_g),
    .st     (dec_st),
    .is_nan (dec_nan),
    .is_inf (dec_inf)
  );

  assign sh_c = '{s: dec_s, i_part: dec_i, g: dec_g, st: dec_st,
                  is_nan: dec_nan, is_inf: dec_inf, rm: rm, uns: is_unsigned};

  if (STAGES >= 2) begin : g_sh_reg
    shift_t sh_q;
    logic   sh_vq;
    // Valid bit behind decode/shift, cleared by reset.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      if (rst)      sh_vq <= 1'b0;
      else if (adv) sh_vq <= in_valid;
    end
    // Decode/shift payload; qualified by sh_vq, so it needs no reset.
    always_ff @(posedge clk) begin
      // NOTE: payload registers are not reset; the valid bit alone says whether they mean anything.
      if (adv) sh_q <= sh_c;
    end
    assign sh_r = sh_q;
    assign sh_v = sh_vq;
  end else begin : g_sh_comb
    assign sh_r = sh_c;
    assign sh_v = in_valid;
  end

  assign inc  = round_inc(sh_r.rm, sh_r.s, sh_r.i_part[0], sh_r.g, sh_r.st);
  assign rd_c = '{s: sh_r.s, mag: sh_r.i_part + {{OUT_W{1'b0}}, inc},
                  gs: sh_r.g | sh_r.st, is_nan: sh_r.is_nan,
                  is_inf: sh_r.is_inf, uns: sh_r.uns};

  if (STAGES == 3) begin : g_rd_reg
    round_t rd_q;
    logic   rd_vq;
    // Valid bit behind rounding, cleared by reset.
    always_ff @(posedge clk) begin
      if (rst)      rd_vq <= 1'b0;
      else if (adv) rd_vq <= sh_v;
    end
    // Rounded magnitude payload.
    always_ff @(posedge clk) begin
      if (adv) rd_q <= rd_c;
    end
    assign rd_r = rd_q;
    assign rd_v = rd_vq;
  end else begin : g_rd_comb
    assign rd_r = rd_c;
    assign rd_v = sh_v;
  end

  // Range check and saturation; NaN always saturates toward the positive end.
  always_comb begin
    y_c      = '0;
    fl_c     = '0;
    in_range = 1'b0;
    if (rd_r.uns) in_range = (!rd_r.s && !rd_r.mag[OUT_W]) || (rd_r.mag == '0);
    else          in_range = rd_r.s ? (rd_r.mag <= HALF) : (rd_r.mag < HALF);
    if (rd_r.is_nan || rd_r.is_inf || !in_range) begin
      fl_c.nv = 1'b1;
      if (rd_r.uns) y_c = (rd_r.s && !rd_r.is_nan) ? '0 : '1;
      else          y_c = (rd_r.s && !rd_r.is_nan) ? {1'b1, {(OUT_W-1){1'b0}}}
                                                   : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      y_c     = rd_r.s ? (ZERO - rd_r.mag[OUT_W-1:0]) : rd_r.mag[OUT_W-1:0];
      fl_c.nx = rd_r.gs;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      fl_q      <= '0;
    end else if (adv) begin
      out_valid <= rd_v;
      y         <= y_c;
      fl_q      <= fl_c;
    end
  end

  assign flag_nv = fl_q.nv;
  assign flag_nx = fl_q.nx;

endmodule

// File: tb/tb_fcvt_ws_pipe.sv
// Scoreboard bench: one converter per STAGES value (1..3), each with its own
// stimulus and monitor, all run from the same clock.
module tb_fcvt_ws_pipe;
  import fcvt_pkg::*;

  localparam int OUT_W = 32;
  localparam int NVEC  = 24;

  typedef struct packed {
    logic [31:0] x;
    logic [2:0]  rm;
    logic        uns;
    logic [31:0] y;
    logic        nv;
    logic        nx;
  } vec_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        nv;
    logic        nx;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-computed vectors: x, rm, unsigned, expected y, nv, nx.
  function automatic vec_t get_vec(input int i);
    case (i)
      0:  return '{32'h40200000, RM_RNE, 1'b0, 32'h00000002, 1'b0, 1'b1};
      1:  return '{32'h40200000, RM_RTZ, 1'b0, 32'h00000002, 1'b0, 1'b1};
      2:  return '{32'h40200000, RM_RDN, 1'b0, 32'h00000002, 1'b0, 1'b1};
      3:  return '{32'h40200000, RM_RUP, 1'b0, 32'h00000003, 1'b0, 1'b1};
      4:  return '{32'h40200000, RM_RMM, 1'b0, 32'h00000003, 1'b0, 1'b1};
      5:  return '{32'hC0200000, RM_RNE, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1};
      6:  return '{32'hC0200000, RM_RDN, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1};
      7:  return '{32'hC0200000, RM_RMM, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1};
      8:  return '{32'hBE99999A, RM_RTZ, 1'b1, 32'h00000000, 1'b0, 1'b1};
      9:  return '{32'h4F000000, RM_RNE, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0};
      10: return '{32'h4F000000, RM_RNE, 1'b1, 32'h80000000, 1'b0, 1'b0};
      11: return '{32'hCF000000, RM_RNE, 1'b0, 32'h80000000, 1'b0, 1'b0};
      12: return '{32'h7FC00000, RM_RNE, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0};
      13: return '{32'hBF800000, RM_RNE, 1'b1, 32'h00000000, 1'b1, 1'b0};
      14: return '{32'h00000001, RM_RUP, 1'b0, 32'h00000001, 1'b0, 1'b1};
      15: return '{32'h80000000, RM_RNE, 1'b0, 32'h00000000, 1'b0, 1'b0};
      16: return '{32'hFF800000, RM_RTZ, 1'b0, 32'h80000000, 1'b1, 1'b0};
      17: return '{32'h7F800000, RM_RNE, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
      18: return '{32'h3F000000, 3'd7,   1'b0, 32'h00000000, 1'b0, 1'b1};
      19: return '{32'h3FC00000, RM_RNE, 1'b0, 32'h00000002, 1'b0, 1'b1};
      20: return '{32'h4F800000, RM_RNE, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
      21: return '{32'h4B000001, RM_RNE, 1'b0, 32'h00800001, 1'b0, 1'b0};
      22: return '{32'hFFC00000, RM_RNE, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
      default: return '{32'h4EFFFFFF, RM_RNE, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0};
    endcase
  endfunction

  for (genvar k = 1; k <= 3; k++) begin : g_st
    localparam int STG = k;

    logic        rst, in_valid, in_ready, uns, out_valid, out_ready, flag_nv, flag_nx;
    logic [31:0] x, y;
    logic [2:0]  rm;
    vec_t        cur;
    exp_t        q[$];

    fcvt_ws_pipe #(.OUT_W(OUT_W), .STAGES(STG)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x           (x),
      .rm          (rm),
      .is_unsigned (uns),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .y           (y),
      .flag_nv     (flag_nv),
      .flag_nx     (flag_nx)
    );

    task automatic drive(input vec_t v);
      cur = v;
      x   = v.x;
      rm  = v.rm;
      uns = v.uns;
    endtask

    task automatic wait_drain(input string name);
      for (int w = 0; w < 30 && q.size() != 0; w++) @(posedge clk);
      #1;
      check($sformatf("S%0d %s", STG, name), 64'(q.size()), 64'd0);
    endtask

    // Monitor: pushes expectations on accept, pops and compares on emit.
    initial begin
      int          cyc = 0;
      int          last_stall = -1;
      logic        held_v = 1'b0;
      logic [31:0] held_y = '0;
      logic [1:0]  held_f = '0;
      exp_t        e;
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          held_v = 1'b0;
        end else begin
          if (out_valid && !out_ready)
            check($sformatf("S%0d in_ready_stall", STG), 64'(in_ready), 64'd0);
          if (held_v) begin
            check($sformatf("S%0d hold_valid", STG), 64'(out_valid), 64'd1);
            check($sformatf("S%0d hold_y", STG), 64'(y), 64'(held_y));
            check($sformatf("S%0d hold_flags", STG), 64'({flag_nv, flag_nx}), 64'(held_f));
          end
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL S%0d unexpected_output: got y=%h expected no result", STG, y);
            end else begin
              e = q.pop_front();
              check($sformatf("S%0d y x=%h", STG, e.x), 64'(y), 64'(e.y));
              check($sformatf("S%0d flags x=%h", STG, e.x),
                    64'({flag_nv, flag_nx}), 64'({e.nv, e.nx}));
              if (e.cyc > last_stall)
                check($sformatf("S%0d latency x=%h", STG, e.x), 64'(cyc - e.cyc), 64'(STG));
            end
          end
          if (out_valid && !out_ready) begin
            held_v     = 1'b1;
            held_y     = y;
            held_f     = {flag_nv, flag_nx};
            last_stall = cyc;
          end else begin
            held_v = 1'b0;
          end
          if (in_valid && in_ready)
            q.push_back('{x: cur.x, y: cur.y, nv: cur.nv, nx: cur.nx, cyc: cyc});
        end
        cyc++;
      end
    end

    // Stimulus: reset, stream with a 3-cycle stall, then reset with work in flight.
    initial begin
      int i = 0;
      int c = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(get_vec(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check($sformatf("S%0d reset_out_valid", STG), 64'(out_valid), 64'd0);
      check($sformatf("S%0d reset_y", STG), 64'(y), 64'd0);
      check($sformatf("S%0d reset_flags", STG), 64'({flag_nv, flag_nx}), 64'd0);
      check($sformatf("S%0d reset_in_ready", STG), 64'(in_ready), 64'd1);

      @(posedge clk); #1;
      while (i < NVEC && c < 400) begin
        out_ready = !(c >= 4 && c <= 6);
        in_valid  = 1'b1;
        drive(get_vec(i));
        @(negedge clk);
        if (in_ready) i++;
        @(posedge clk); #1;
        c++;
      end
      check($sformatf("S%0d stream_issued", STG), 64'(i), 64'(NVEC));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain("stream_drain");

      @(posedge clk); #1;
      in_valid = 1'b1;
      drive(get_vec(0));
      @(posedge clk); #1;
      drive(get_vec(5));
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("S%0d midrst_out_valid", STG), 64'(out_valid), 64'd0);
      check($sformatf("S%0d midrst_y", STG), 64'(y), 64'd0);
      check($sformatf("S%0d midrst_in_ready", STG), 64'(in_ready), 64'd1);
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        check($sformatf("S%0d no_pulse_after_rst", STG), 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      drive(get_vec(3));
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain("post_rst_drain");
      n_done++;
    end
  end

  // Wait for all three converters, bounded, then report.
  initial begin
    for (int w = 0; w < 3000 && n_done < 3; w++) @(posedge clk);
    if (n_done < 3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d finished benches expected 3", n_done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fcvt_ws_pipe.md
Name: fcvt_ws_pipe

Overview:
Pipelined float-to-integer converter for FCVT.W.S / FCVT.WU.S. It takes an IEEE-754 single and produces a signed or unsigned OUT_W-bit integer. It supports all five RISC-V rounding modes, saturation, and NV/NX exception flags. It sits in the FPU issue path behind a valid/ready handshake and replaces the combinational round-half-away converter; that converter's results are reproduced when rm=RMM and the input is in range.

Parameters:
OUT_W, 32, result width; legal 32 or 64.
STAGES, 2, register stages from accept to result; legal 1..3.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  operand valid
in_ready  out  1  converter can accept this cycle
x  in  32  IEEE-754 single operand
rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5..7 treated as RNE
is_unsigned  in  1  1 = WU conversion, 0 = W
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
y  out  OUT_W  integer result
flag_nv  out  1  invalid: NaN, infinity, or out of range
flag_nx  out  1  inexact: result differs from the operand and NV=0

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: every stage valid bit cleared, so out_valid=0. y, flag_nv and flag_nx reset to 0. in_ready=1 in the first cycle after reset.
- Handshake:
  - adv = !out_valid || out_ready; in_ready = adv.
  - When adv=1, all stages shift by one; when adv=0, every stage register holds.
  - A transfer occurs when in_valid && in_ready, or when out_valid && out_ready.
- Latency and throughput: with no back-pressure, a value accepted in cycle t appears with out_valid=1 in cycle t+STAGES. Throughput is 1 per cycle.
- Output hold: while out_valid && !out_ready, y and flags are stable.
- Stage placement:
  - STAGES=1: output register only.
  - STAGES=2: adds a register after decode/shift.
  - STAGES=3: adds a further register after rounding, before saturation.
- Decode: s, e, m. Significand sig = {e!=0, m}. Subnormals are nonzero tiny values. Unbiased exponent E = e-127.
- Shift: produce integer part I (OUT_W+1 bits), guard bit G and sticky bit S.
  - E<0: I=0; G=(E==-1); S = any remaining significand bit.
  - E>=23: left shift with G=S=0, capped once E>OUT_W.
- Round increment inc:
  - RNE: G&(S|I[0])
  - RTZ: 0
  - RDN: s&(G|S)
  - RUP: !s&(G|S)
  - RMM: G
- Magnitude: mag = I+inc, computed one bit wider than OUT_W.
- Signed range: valid when mag ≤ 2^(OUT_W-1)-1 for s=0, or mag ≤ 2^(OUT_W-1) for s=1. Result is s ? -mag : mag.
- Unsigned range: valid when s=0 and mag ≤ 2^OUT_W-1, or when mag=0 (this includes negative values that round to 0).
- Saturation (sets NV=1, NX=0):
  - NaN: signed → max positive; unsigned → all ones.
  - +inf or positive overflow: same as NaN.
  - -inf or negative overflow: signed → min negative; unsigned → 0.
- Exact flags: NX = (G|S) when NV=0. ±0 gives 0 with no flags. -0.3 as WU with RTZ gives 0 with NX=1, NV=0.
- Reset during operation: all in-flight results are discarded; no out_valid pulse follows reset.
- Simultaneous accept and emit under adv=1 is the normal streaming case. Nothing is lost or duplicated.

Decomposition:
- Package fcvt_pkg:
  - rounding-mode localparams RM_RNE..RM_RMM
  - packed struct fcvt_flags_t {nv, nx}
  - function round_inc(rm, s, lsb, g, st)
- Sub-module fcvt_ws_shift (combinational): x and OUT_W → {s, I, G, S, is_nan, is_inf}. It is reused by the planned fcvt_ls (64-bit) path.
- The top level holds the stage registers, handshake, rounding and saturation.

Test Plan:
- x=0x40200000 (2.5), signed, OUT_W=32 → per rm: RNE 2, RTZ 2, RDN 2, RUP 3, RMM 3; NX=1 in every mode.
- x=0xC0200000 (-2.5) → RNE 0xFFFFFFFE, RDN 0xFFFFFFFD, RMM 0xFFFFFFFD. x=0xBE99999A (-0.3), WU, RTZ → y=0, NX=1, NV=0.
- x=0x4F000000 (2^31): signed → 0x7FFFFFFF, NV=1; WU → 0x80000000, no flags. x=0xCF000000 signed → 0x80000000, no flags. x=0x7FC00000 (NaN) signed → 0x7FFFFFFF, NV=1.
- x=0xBF800000 (-1.0), WU → 0, NV=1. x=0x00000001 (subnormal), RUP → 1, NX=1.
- Streaming plus back-pressure, STAGES=1..3:
  - Drive 10 back-to-back operands with out_ready low for 3 cycles mid-stream.
  - Required: in-order results with latency STAGES; y/flags held while stalled; in_ready=0 whenever out_valid&&!out_ready.
- Reset mid-operation: assert rst with 2 operands in flight → next cycle out_valid=0, y=0, in_ready=1. The following operand returns after exactly STAGES cycles.
